// File: rtl/dma_rotating_arbiter.sv
// ============================================================================
// dma_rotating_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   DMA channel priority arbiter for NUM_CH channels. Picks one valid request
//   (dreq & ~mask), issues a registered one-hot grant and holds it until the
//   transfer-timing FSM pulses i_done. Priority is either fixed (channel 0
//   highest) or rotating (the channel just served drops to lowest priority),
//   chosen at run time by i_rotate_mode. After every service there is one
//   RECOVER cycle with the grant low so DACK deasserts between transfers.
//
// Parameters:
//   NUM_CH        number of DMA channels (2..16)
//   IDX_W         width of the channel index outputs
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-low reset
//   i_rotate_mode 1 = rotating priority, 0 = fixed priority (ch0 highest)
//   i_dreq        raw channel requests, level-sensitive, already synchronised
//   i_mask        1 = channel masked (ignored)
//   i_done        single-cycle pulse: current service complete
//   o_grant       one-hot grant (DACK select), all-zero when idle
//   o_grant_valid 1 while a grant is held
//   o_grant_idx   binary index of the granted channel, 0 when idle
//   o_prio_base   index of the current highest-priority channel
// ============================================================================
module dma_rotating_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_rotate_mode,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_done,
    output logic [NUM_CH-1:0] o_grant,
    output logic              o_grant_valid,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic [IDX_W-1:0]  o_prio_base
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT   = 3'b010,
        ST_RECOVER = 3'b100
    } state_t;

    localparam logic [IDX_W:0]      CH_COUNT = (IDX_W+1)'(NUM_CH);
    localparam logic [NUM_CH-1:0]   ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [NUM_CH-1:0]   r_grant;
    logic [IDX_W-1:0]    r_grantIdx;
    logic [IDX_W-1:0]    r_prioBase;

    state_t              w_nextState;
    logic [NUM_CH-1:0]   w_nextGrant;
    logic [IDX_W-1:0]    w_nextGrantIdx;
    logic [IDX_W-1:0]    w_nextPrioBase;

    logic [NUM_CH-1:0]   w_vreq;
    logic [IDX_W-1:0]    w_effBase;
    logic [IDX_W:0]      w_scan;
    logic                w_selFound;
    logic [IDX_W-1:0]    w_selIdx;
    logic [NUM_CH-1:0]   w_selOnehot;
    logic [IDX_W:0]      w_incIdx;
    logic [IDX_W-1:0]    w_rotBase;
    logic                w_abort;

    assign w_vreq = i_dreq & ~i_mask;

    // In fixed mode channel 0 is always on top, even on the very cycle the
    // mode drops before the base register has been cleared.
    assign w_effBase = i_rotate_mode ? r_prioBase : '0;

    // Wrap-around priority scan: visit base, base+1, ... modulo NUM_CH and
    // keep the first valid request. Done with a short counter instead of a
    // power-of-two mask so that non-power-of-two channel counts wrap right.
    always_comb begin
        w_selFound = 1'b0;
        w_selIdx   = '0;
        w_scan     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, w_effBase} + (IDX_W+1)'(k);
            if (w_scan >= CH_COUNT) begin
                w_scan = w_scan - CH_COUNT;
            end
            if (!w_selFound && w_vreq[w_scan[IDX_W-1:0]]) begin
                w_selFound = 1'b1;
                w_selIdx   = w_scan[IDX_W-1:0];
            end
        end
    end

    assign w_selOnehot = ONE_HOT0 << w_selIdx;

    // Channel after the one being served, wrapped at NUM_CH; one extra bit
    // keeps the +1 from overflowing when NUM_CH is a power of two.
    assign w_incIdx  = {1'b0, r_grantIdx} + (IDX_W+1)'(1);
    assign w_rotBase = (w_incIdx >= CH_COUNT) ? '0 : w_incIdx[IDX_W-1:0];

    // Mask raised on the channel currently holding the grant.
    assign w_abort = |(i_mask & r_grant);

    always_comb begin
        w_nextState    = r_state;
        w_nextGrant    = r_grant;
        w_nextGrantIdx = r_grantIdx;
        w_nextPrioBase = i_rotate_mode ? r_prioBase : '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_selFound) begin
                    w_nextState    = ST_GRANT;
                    w_nextGrant    = w_selOnehot;
                    w_nextGrantIdx = w_selIdx;
                end
            end

            ST_GRANT: begin
                // done takes precedence over a simultaneous mask abort so the
                // completed service still rotates priority.
                if (i_done) begin
                    w_nextState    = ST_RECOVER;
                    w_nextGrant    = '0;
                    w_nextGrantIdx = '0;
                    if (i_rotate_mode) begin
                        w_nextPrioBase = w_rotBase;
                    end
                end else if (w_abort) begin
                    w_nextState    = ST_RECOVER;
                    w_nextGrant    = '0;
                    w_nextGrantIdx = '0;
                end
            end

            ST_RECOVER: begin
                w_nextState    = ST_IDLE;
                w_nextGrant    = '0;
                w_nextGrantIdx = '0;
            end

            default: begin
                w_nextState    = ST_IDLE;
                w_nextGrant    = '0;
                w_nextGrantIdx = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_prioBase <= '0;
        end else begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_grantIdx <= w_nextGrantIdx;
            r_prioBase <= w_nextPrioBase;
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = (r_state == ST_GRANT);
    assign o_grant_idx   = r_grantIdx;
    assign o_prio_base   = r_prioBase;

endmodule

// File: tb/tb_dma_rotating_arbiter.sv
// ============================================================================
// tb_dma_rotating_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for dma_rotating_arbiter. A 4-channel instance is
//   exercised by directed scenarios and by a randomized run compared against
//   a behavioural reference model; an 8-channel instance covers the wrap at
//   a wider channel count.
// ============================================================================
module tb_dma_rotating_arbiter;

    localparam int N4 = 4;

    logic       clock;

    logic       reset4, rotate4, done4;
    logic [3:0] dreq4, mask4, grant4;
    logic       valid4;
    logic [1:0] idx4, base4;

    logic       reset8, rotate8, done8;
    logic [7:0] dreq8, mask8, grant8;
    logic       valid8;
    logic [2:0] idx8, base8;

    int testsRun;
    int testsFailed;

    // Reference model of the 4-channel instance: granted channel (-1 none),
    // recovery flag and priority base.
    int mG;
    bit mRec;
    int mBase;

    logic [3:0] edgeVreq;
    logic [3:0] prevGrant;

    dma_rotating_arbiter #(.NUM_CH(4)) dut4 (
        .clock         (clock),
        .reset         (reset4),
        .i_rotate_mode (rotate4),
        .i_dreq        (dreq4),
        .i_mask        (mask4),
        .i_done        (done4),
        .o_grant       (grant4),
        .o_grant_valid (valid4),
        .o_grant_idx   (idx4),
        .o_prio_base   (base4)
    );

    dma_rotating_arbiter #(.NUM_CH(8)) dut8 (
        .clock         (clock),
        .reset         (reset8),
        .i_rotate_mode (rotate8),
        .i_dreq        (dreq8),
        .i_mask        (mask8),
        .i_done        (done8),
        .o_grant       (grant8),
        .o_grant_valid (valid8),
        .o_grant_idx   (idx8),
        .o_prio_base   (base8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic rst, input logic mode,
                                 input logic [3:0] d, input logic [3:0] m,
                                 input logic dn);
        reset4  = rst;
        rotate4 = mode;
        dreq4   = d;
        mask4   = m;
        done4   = dn;
    endtask

    // Reference behaviour: the winner is the valid requester at the smallest
    // circular distance from the effective priority base.
    task automatic modelStep();
        int nb, eb, best, bestD, d;
        logic [3:0] v;
        if (!reset4) begin
            mG = -1; mRec = 1'b0; mBase = 0;
            return;
        end
        nb = rotate4 ? mBase : 0;
        if (mRec) begin
            mRec = 1'b0;
        end else if (mG >= 0) begin
            if (done4) begin
                if (rotate4) nb = (mG + 1) % N4;
                mG = -1; mRec = 1'b1;
            end else if (mask4[mG]) begin
                mG = -1; mRec = 1'b1;
            end
        end else begin
            v = dreq4 & ~mask4;
            eb = rotate4 ? mBase : 0;
            best = -1; bestD = N4;
            for (int ch = 0; ch < N4; ch++) begin
                if (v[ch]) begin
                    d = (ch - eb + N4) % N4;
                    if (d < bestD) begin bestD = d; best = ch; end
                end
            end
            mG = best;
        end
        mBase = nb;
    endtask

    task automatic tick();
        edgeVreq  = dreq4 & ~mask4;
        prevGrant = grant4;
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
        tick(); tick();
        testsRun++;
        if (grant4 !== 4'b0000 || valid4 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_grant: got grant=%b valid=%b, expected 0000/0", grant4, valid4);
        end
        testsRun++;
        if (base4 !== 2'd0 || idx4 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_base: got base=%0d idx=%0d, expected 0/0", base4, idx4);
        end
        reset4 = 1'b1;
        tick();
        testsRun++;
        if (grant4 !== 4'b0001 || idx4 !== 2'd0 || valid4 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got grant=%b idx=%0d valid=%b, expected 0001/0/1", grant4, idx4, valid4);
        end
        reset4 = 1'b0;
        done4  = 1'b1;
        tick();
        done4 = 1'b0;
        testsRun++;
        if (grant4 !== 4'b0000 || valid4 !== 1'b0 || base4 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_service: got grant=%b valid=%b base=%0d, expected 0000/0/0", grant4, valid4, base4);
        end
    endtask

    task automatic test_fixed_priority();
        applyStimulus(1'b0, 1'b0, 4'b1010, 4'h0, 1'b0);
        tick();
        reset4 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (grant4 !== 4'b0010 || base4 !== 2'd0) begin
                testsFailed++;
                $display("[TB] FAIL fixed_grant[%0d]: got grant=%b base=%0d, expected 0010/0", i, grant4, base4);
            end
            done4 = 1'b1;
            tick();
            done4 = 1'b0;
            testsRun++;
            if (grant4 !== 4'b0000 || base4 !== 2'd0) begin
                testsFailed++;
                $display("[TB] FAIL fixed_dead1[%0d]: got grant=%b base=%0d, expected 0000/0", i, grant4, base4);
            end
            tick();
            testsRun++;
            if (grant4 !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL fixed_dead2[%0d]: got grant=%b, expected 0000", i, grant4);
            end
            tick();
        end
    endtask

    task automatic test_rotating_fairness();
        logic [3:0] expG;
        logic [1:0] expB;
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        tick();
        reset4 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            expG = 4'(1 << (i % 4));
            testsRun++;
            if (grant4 !== expG) begin
                testsFailed++;
                $display("[TB] FAIL rotate_grant[%0d]: got grant=%b, expected %b", i, grant4, expG);
            end
            if (i < 4) begin
                tick(); tick();
                done4 = 1'b1;
                tick();
                done4 = 1'b0;
                expB = 2'((i + 1) % 4);
                testsRun++;
                if (base4 !== expB || grant4 !== 4'b0000) begin
                    testsFailed++;
                    $display("[TB] FAIL rotate_base[%0d]: got base=%0d grant=%b, expected %0d/0000", i, base4, grant4, expB);
                end
                tick(); tick();
            end
        end
    endtask

    task automatic test_wrap_and_mask();
        applyStimulus(1'b0, 1'b1, 4'b0100, 4'h0, 1'b0);
        tick();
        reset4 = 1'b1;
        tick();
        done4 = 1'b1;
        tick();
        done4 = 1'b0;
        dreq4 = 4'b1001;
        mask4 = 4'b1000;
        testsRun++;
        if (base4 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL wrap_setup_base: got base=%0d, expected 3", base4);
        end
        tick(); tick();
        testsRun++;
        if (grant4 !== 4'b0001 || idx4 !== 2'd0 || base4 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL wrap_grant: got grant=%b idx=%0d base=%0d, expected 0001/0/3", grant4, idx4, base4);
        end
        mask4 = 4'b1001;
        tick();
        testsRun++;
        if (grant4 !== 4'b0000 || valid4 !== 1'b0 || base4 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL mask_abort: got grant=%b valid=%b base=%0d, expected 0000/0/3", grant4, valid4, base4);
        end
        tick();
        testsRun++;
        if (grant4 !== 4'b0000 || base4 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL mask_idle: got grant=%b base=%0d, expected 0000/3", grant4, base4);
        end
    endtask

    task automatic test_simultaneous();
        applyStimulus(1'b0, 1'b1, 4'b0100, 4'h0, 1'b0);
        tick();
        reset4 = 1'b1;
        tick();
        rotate4 = 1'b0;
        dreq4   = 4'b0001;
        tick();
        testsRun++;
        if (grant4 !== 4'b0100 || idx4 !== 2'd2) begin
            testsFailed++;
            $display("[TB] FAIL grant_frozen: got grant=%b idx=%0d, expected 0100/2", grant4, idx4);
        end
        rotate4 = 1'b1;
        done4   = 1'b1;
        mask4   = 4'b0100;
        tick();
        done4 = 1'b0;
        testsRun++;
        if (grant4 !== 4'b0000 || base4 !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL done_beats_mask: got grant=%b base=%0d, expected 0000/3", grant4, base4);
        end
        dreq4 = 4'b0000;
        mask4 = 4'b0000;
        tick();
        done4 = 1'b1;
        tick();
        done4 = 1'b0;
        tick();
        testsRun++;
        if (grant4 !== 4'b0000 || base4 !== 2'd3 || valid4 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL done_in_idle: got grant=%b base=%0d valid=%b, expected 0000/3/0", grant4, base4, valid4);
        end
    endtask

    task automatic test_nch8();
        reset8 = 1'b0; rotate8 = 1'b1; dreq8 = 8'h01; mask8 = 8'h00; done8 = 1'b0;
        tick();
        reset8 = 1'b1;
        tick();
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        dreq8 = 8'h81;
        testsRun++;
        if (base8 !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL n8_base_setup: got base=%0d, expected 1", base8);
        end
        tick(); tick();
        testsRun++;
        if (grant8 !== 8'h80 || idx8 !== 3'd7 || valid8 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL n8_grant7: got grant=%h idx=%0d valid=%b, expected 80/7/1", grant8, idx8, valid8);
        end
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        testsRun++;
        if (base8 !== 3'd0 || grant8 !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL n8_wrap_base: got base=%0d grant=%h, expected 0/00", base8, grant8);
        end
        tick(); tick();
        testsRun++;
        if (grant8 !== 8'h01 || idx8 !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL n8_grant0: got grant=%h idx=%0d, expected 01/0", grant8, idx8);
        end
    endtask

    task automatic test_random();
        logic [3:0] expG;
        logic [1:0] expIdx, expBase;
        logic       expValid;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        reset4 = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 15) == 0) rotate4 = ~rotate4;
            dreq4  = 4'($urandom);
            mask4  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            done4  = !done4 && ($urandom_range(0, 3) == 0);
            reset4 = ($urandom_range(0, 199) != 0);
            tick();
            expValid = (mG >= 0);
            expG     = expValid ? 4'(1 << mG) : 4'b0000;
            expIdx   = expValid ? 2'(mG) : 2'd0;
            expBase  = 2'(mBase);
            testsRun++;
            if (grant4 !== expG || valid4 !== expValid || idx4 !== expIdx || base4 !== expBase) begin
                testsFailed++;
                $display("[TB] FAIL random_model[%0d]: got grant=%b valid=%b idx=%0d base=%0d, expected grant=%b valid=%b idx=%0d base=%0d",
                         cyc, grant4, valid4, idx4, base4, expG, expValid, expIdx, expBase);
            end
            testsRun++;
            if ($countones(grant4) > 1 || valid4 !== (|grant4) ||
                (valid4 && grant4 !== (4'b0001 << idx4)) || (!valid4 && idx4 !== 2'd0)) begin
                testsFailed++;
                $display("[TB] FAIL random_invariant[%0d]: got grant=%b valid=%b idx=%0d, required one-hot grant consistent with valid/idx",
                         cyc, grant4, valid4, idx4);
            end
            if (grant4 !== 4'b0000 && prevGrant === 4'b0000 && reset4) begin
                testsRun++;
                if ((grant4 & edgeVreq) !== grant4) begin
                    testsFailed++;
                    $display("[TB] FAIL random_origin[%0d]: got grant=%b, required subset of arbitration vreq=%b",
                             cyc, grant4, edgeVreq);
                end
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        mG    = -1;
        mRec  = 1'b0;
        mBase = 0;
        reset8 = 1'b0; rotate8 = 1'b0; dreq8 = 8'h00; mask8 = 8'h00; done8 = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        edgeVreq  = 4'h0;
        prevGrant = 4'h0;
        #2;
        test_reset();
        test_fixed_priority();
        test_rotating_fairness();
        test_wrap_and_mask();
        test_simultaneous();
        test_nch8();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dma_rotating_arbiter.md
Name: dma_rotating_arbiter

Overview:
- Parametrised DMA channel priority arbiter. Successor to the fixed 4-channel rotating-priority encoder.
- Selects one of NUM_CH masked requests and holds the grant until the transfer engine signals completion.
- Supports fixed priority (channel 0 highest) or rotating priority (the last-served channel drops to lowest), selected at run time.
- Sits between the request/mask registers and the DMA transfer-timing FSM.

Parameters:
NUM_CH, 4, number of DMA channels (2..16)
IDX_W, $clog2(NUM_CH), width of channel index outputs

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
rotate_mode  in  1  1 = rotating priority, 0 = fixed priority (ch0 highest)
dreq  in  NUM_CH  raw channel requests, level-sensitive, already synchronised
mask  in  NUM_CH  1 = channel masked (ignored)
done  in  1  single-cycle pulse from transfer FSM: current service complete
grant  out  NUM_CH  one-hot grant (DACK select); all-zero when idle
grant_valid  out  1  1 while a grant is held
grant_idx  out  IDX_W  binary index of granted channel; 0 when idle
prio_base  out  IDX_W  index of the current highest-priority channel

Behaviour:
- Valid request vector: vreq = dreq & ~mask.
- Reset (reset==0 at posedge):
  - state = IDLE.
  - grant = 0, grant_valid = 0, grant_idx = 0, prio_base = 0.
  - Reset mid-service drops the grant on the same edge; done is ignored during reset.
- States: IDLE, GRANT, RECOVER (one-hot encoded).
- IDLE:
  - If vreq != 0, go to GRANT next cycle.
  - Selected channel = first set bit of vreq scanning prio_base, prio_base+1, ... modulo NUM_CH (wrap-around).
  - grant, grant_valid and grant_idx are registered and become valid on that edge: 1-cycle latency from dreq to grant.
  - If vreq == 0, stay in IDLE.
- GRANT:
  - grant is frozen; later dreq changes on other channels are ignored.
  - done=1: go to RECOVER and clear grant/grant_valid/grant_idx. If rotate_mode=1, prio_base <= (grant_idx+1) mod NUM_CH.
  - Granted channel's mask bit becomes 1 (abort) with done=0: go to RECOVER, clear grant, prio_base unchanged.
  - Mask abort and done in the same cycle: done wins (rotation applied).
  - Granted dreq drops while unmasked: grant held; the transfer FSM owns termination.
- RECOVER:
  - One dead cycle with grant = 0 so DACK deasserts between services.
  - Always go to IDLE; no arbitration in this state.
  - Minimum spacing between grants is therefore 2 idle cycles after done.
- Mode rules:
  - While rotate_mode=0, prio_base is forced to 0 every cycle.
  - Switching 0->1 starts rotation from base 0.
  - A mode change during GRANT does not affect the held grant.
- done asserted in IDLE or RECOVER: ignored, no state or pointer change.
- Invariants (bench must check):
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches grant.
  - A granted channel was unmasked and requesting in the arbitration cycle.

Test Plan:
- Reset: hold reset=0 with dreq=4'hF. Expect grant=0, prio_base=0. Release reset: next cycle grant=4'b0001, grant_idx=0.
- Fixed priority: rotate_mode=0, dreq=4'b1010 constant, pulse done after each grant. Expect grant=4'b0010 every time (ch1 starves ch3), prio_base stays 0, 2 dead cycles between grants.
- Rotating fairness: rotate_mode=1, dreq=4'hF held, done 3 cycles after each grant. Expect grant sequence ch0, ch1, ch2, ch3, ch0 and prio_base sequence 1, 2, 3, 0.
- Wrap and mask: rotate_mode=1, prio_base=3, dreq=4'b1001, mask=4'b1000. Expect grant ch0. Then set mask[0]=1 mid-grant with done=0: grant clears next edge, prio_base stays 3.
- Simultaneous events: in GRANT on ch2, assert done and mask[2] in the same cycle. Expect RECOVER and prio_base=3. Also pulse done in IDLE: no change.
- NUM_CH=8 instance: rotate_mode=1, dreq=8'h81, prio_base=1. Expect grant ch7 (idx 7), then after done prio_base=0 and the next grant is ch0.
